writeback_register_file: RTL and testbench
==========================================

// Module: writeback_register_file
// PURPOSE
// - Consumer end of the MEM/WB pipeline register: selects the writeback value
//   (memory load data or ALU/calculated data) and commits it to the architectural
//   register file.
// - Serves two combinational read ports to decode, with same-cycle write->read bypass.
// - Holds a pending-write scoreboard, set at issue and cleared at writeback.
//   It raises a stall for RAW/WAW hazards that the pipeline cannot forward.
// PARAMETERS
// - DATA_WIDTH  16  width of each register and of both writeback data inputs
// - NUM_REGS    16  number of architectural registers; register 0 is hardwired to zero
// - ADDR_WIDTH  $clog2(NUM_REGS)  register index width (derived; do not override)
// PORTS
// - clk                  in   1           system clock, all state updates on rising edge
// - reset                in   1           asynchronous, active-high; clears all state
// - wb_valid             in   1           writeback request valid this cycle
// - wb_mem_to_reg        in   1           1: write data_from_memory_in; 0: write calc_data_in
// - wb_addr              in   ADDR_WIDTH  destination register of the writeback
// - data_from_memory_in  in   DATA_WIDTH  load data from MEM/WB register
// - calc_data_in         in   DATA_WIDTH  calculated data from MEM/WB register
// - rs1_addr             in   ADDR_WIDTH  read port 1 index (decode)
// - rs2_addr             in   ADDR_WIDTH  read port 2 index (decode)
// - rs1_data             out  DATA_WIDTH  read port 1 data (combinational)
// - rs2_data             out  DATA_WIDTH  read port 2 data (combinational)
// - issue_valid          in   1           decode wants to issue an instruction this cycle
// - issue_writes         in   1           issuing instruction writes a register
// - issue_rd_addr        in   ADDR_WIDTH  destination of issuing instruction
// - stall                out  1           hazard detected; issue is not accepted
// - pending_mask         out  NUM_REGS    scoreboard bits (bit i = write to reg i in flight)
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - All registers go to 0 and pending_mask goes to 0.
//   - With addresses at 0, rs1_data, rs2_data and stall are 0.
// - Writeback data:
//   - wb_data = wb_mem_to_reg ? data_from_memory_in : calc_data_in.
//   - Written at the rising edge when wb_valid=1 and wb_addr!=0.
//   - wb_addr==0 is silently dropped.
// - Read ports:
//   - rsN_data = 0 if rsN_addr==0.
//   - Otherwise rsN_data = wb_data if wb_valid and wb_addr==rsN_addr (bypass, zero latency).
//   - Otherwise rsN_data = regs[rsN_addr].
// - Scoreboard:
//   - clr[i] = wb_valid & (wb_addr==i).
//   - set[i] = issue_valid & issue_writes & ~stall & (issue_rd_addr==i).
//   - Bit 0 is never set.
//   - Next pending[i] = set[i] | (pending[i] & ~clr[i]); set wins when set and clear hit the same register.
// - Hazard (effective pending eff[i] = pending[i] & ~clr[i], since the bypass resolves the clearing write):
//   - stall = issue_valid & (eff[rs1_addr] | eff[rs2_addr] | (issue_writes & eff[issue_rd_addr])).
//   - Register 0 never causes stall. stall is purely combinational, so issue and stall are decided in the same cycle.
//   - A stalled issue changes no state; decode holds its inputs and retries.
// - Writebacks are always accepted, including while stalling; there is no backpressure on the WB side.
// - Reset asserted mid-operation discards all in-flight pending bits immediately (async), independent of clk.
// - X on wb_addr/wb_data when wb_valid=0 must not propagate to any output.
// TESTING
// - Reset, then read r1..r15 -> all 0; pending_mask=0; stall=0.
// - wb_valid=1, wb_addr=3, wb_mem_to_reg=0, calc=16'hBEEF, rs1_addr=3 in the same cycle
//   -> rs1_data=16'hBEEF (bypass); next cycle regs[3]=16'hBEEF.
// - Issue rd=5 (issue_writes=1) -> pending_mask[5]=1; next issue with rs2_addr=5 -> stall=1 and no state change.
//   Then WB to r5 with mem=16'h1234, wb_mem_to_reg=1 -> same-cycle stall=0 and rs2_data=16'h1234.
// - Same cycle: WB clears r7 and issue sets rd=7 -> pending_mask[7]=1 after the edge (set wins).
// - WB to r0 with 16'hFFFF, issue rd=0, read rs1=0 -> rs1_data=0, pending_mask[0]=0, stall=0.
// - Pending r2, r9 set; assert reset between edges -> pending_mask=0 and regs=0 without a clock edge.

Source files
------------

// File: rtl/writeback_register_file_if.sv
// Bundles the writeback, read-port and issue/scoreboard signals of writeback_register_file.
//   master : pipeline side. Drives the writeback request, the read indices and the issue request.
//            Receives the read data, stall and pending_mask.
//   slave  : register file side. This is the mirror image of master.
// Signals:
//   wb_valid, wb_mem_to_reg, wb_addr, data_from_memory_in, calc_data_in : MEM/WB writeback
//   rs1_addr, rs2_addr / rs1_data, rs2_data                             : decode read ports
//   issue_valid, issue_writes, issue_rd_addr / stall, pending_mask      : hazard scoreboard
interface writeback_register_file_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
);
    logic                  wb_valid;
    logic                  wb_mem_to_reg;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] data_from_memory_in;
    logic [DATA_WIDTH-1:0] calc_data_in;

    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    logic                  issue_valid;
    logic                  issue_writes;
    logic [ADDR_WIDTH-1:0] issue_rd_addr;
    logic                  stall;
    logic [NUM_REGS-1:0]   pending_mask;

    modport master (
        output wb_valid, wb_mem_to_reg, wb_addr, data_from_memory_in, calc_data_in,
        output rs1_addr, rs2_addr,
        output issue_valid, issue_writes, issue_rd_addr,
        input  rs1_data, rs2_data, stall, pending_mask
    );

    modport slave (
        input  wb_valid, wb_mem_to_reg, wb_addr, data_from_memory_in, calc_data_in,
        input  rs1_addr, rs2_addr,
        input  issue_valid, issue_writes, issue_rd_addr,
        output rs1_data, rs2_data, stall, pending_mask
    );
endinterface

// File: rtl/writeback_register_file.sv
// Writeback stage and architectural register file with a pending-write scoreboard.
// - Selects the load data or the calculated data and commits it to the register file.
//   A writeback to register 0 is dropped.
// - Two combinational read ports. A writeback in the same cycle is bypassed to them.
// - Scoreboard bits are set when an instruction issues and cleared when its writeback lands.
//   When a source or destination is still in flight, stall is raised for the issuing instruction.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high. Clears the registers and the scoreboard.
//   bus   : writeback_register_file_if.slave (writeback, read ports, issue/stall/pending_mask)
module writeback_register_file #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    writeback_register_file_if.slave  bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;

    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_we;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic [NUM_REGS-1:0]   clr;
    logic [NUM_REGS-1:0]   set;
    logic [NUM_REGS-1:0]   eff;
    logic                  stall;
    logic                  issue_ok;

    // Writeback select and commit enable
    always_comb begin
        wb_data = bus.wb_mem_to_reg ? bus.data_from_memory_in : bus.calc_data_in;
        wb_we   = bus.wb_valid && (bus.wb_addr != '0);
    end

    // Read ports. Every use of the writeback fields is gated by wb_valid, so X on the
    // idle writeback bus cannot reach the read data.
    always_comb begin
        rs1_hit = bus.wb_valid && (bus.wb_addr == bus.rs1_addr);
        rs2_hit = bus.wb_valid && (bus.wb_addr == bus.rs2_addr);

        if (bus.rs1_addr == '0) begin
            bus.rs1_data = '0;
        end else if (rs1_hit) begin
            bus.rs1_data = wb_data;
        end else begin
            bus.rs1_data = regs_q[bus.rs1_addr];
        end

        if (bus.rs2_addr == '0) begin
            bus.rs2_data = '0;
        end else if (rs2_hit) begin
            bus.rs2_data = wb_data;
        end else begin
            bus.rs2_data = regs_q[bus.rs2_addr];
        end
    end

    // Scoreboard clear and effective pending bits. A bit that is cleared this cycle
    // does not hazard, because the bypass already supplies its value.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            clr[i] = bus.wb_valid && (bus.wb_addr == ADDR_WIDTH'(i));
        end
        eff = pending_q & ~clr;
    end

    // Hazard detection. Bit 0 of pending_q is never set, so register 0 cannot stall.
    always_comb begin
        stall = bus.issue_valid &&
                (eff[bus.rs1_addr] || eff[bus.rs2_addr] ||
                 (bus.issue_writes && eff[bus.issue_rd_addr]));
        issue_ok = bus.issue_valid && bus.issue_writes && !stall;
    end

    // Scoreboard next state. When set and clear hit the same register, set wins.
    always_comb begin
        set = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            set[i] = issue_ok && (bus.issue_rd_addr == ADDR_WIDTH'(i));
        end
        pending_d    = set | (pending_q & ~clr);
        pending_d[0] = 1'b0;
    end

    // Register file next state
    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[bus.wb_addr] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.pending_mask = pending_q;

endmodule

// File: tb/tb_writeback_register_file.sv
module tb_writeback_register_file;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 16;

    localparam logic [1:0] SelRs1  = 2'd0;
    localparam logic [1:0] SelRs2  = 2'd1;
    localparam logic [1:0] SelStl  = 2'd2;
    localparam logic [1:0] SelPend = 2'd3;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exp_t  exp_q[$];
    string name_q[$];

    writeback_register_file_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    writeback_register_file #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string nm, input logic [1:0] sel, input logic [31:0] e);
        exp_t x;
        x.sel = sel;
        x.exp = e;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.wb_valid            = 1'b0;
        bus.wb_mem_to_reg       = 1'b0;
        bus.wb_addr             = '0;
        bus.data_from_memory_in = '0;
        bus.calc_data_in        = '0;
        bus.rs1_addr            = '0;
        bus.rs2_addr            = '0;
        bus.issue_valid         = 1'b0;
        bus.issue_writes        = 1'b0;
        bus.issue_rd_addr       = '0;
    endtask

    task automatic issue(input logic [3:0] rd, input logic wr, input logic [3:0] r1,
                         input logic [3:0] r2);
        bus.issue_valid   = 1'b1;
        bus.issue_writes  = wr;
        bus.issue_rd_addr = rd;
        bus.rs1_addr      = r1;
        bus.rs2_addr      = r2;
    endtask

    task automatic wb(input logic [3:0] a, input logic m2r, input logic [15:0] mem,
                      input logic [15:0] calc);
        bus.wb_valid            = 1'b1;
        bus.wb_mem_to_reg       = m2r;
        bus.wb_addr             = a;
        bus.data_from_memory_in = mem;
        bus.calc_data_in        = calc;
    endtask

    // Monitor: outputs are settled at the falling edge; drain all expectations queued
    // for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t        x;
                string       nm;
                logic [31:0] act;
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (x.sel)
                    SelRs1:  act = 32'(bus.rs1_data);
                    SelRs2:  act = 32'(bus.rs2_data);
                    SelStl:  act = 32'(bus.stall);
                    default: act = 32'(bus.pending_mask);
                endcase
                checks++;
                if (act !== x.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", nm, act, x.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_bus();
        step();
        expect_out("rst_pending", SelPend, 32'h0);
        expect_out("rst_stall", SelStl, 32'h0);
        expect_out("rst_rs1", SelRs1, 32'h0);
        step();
        reset = 1'b0;
        step();

        for (int r = 1; r < 16; r++) begin
            bus.rs1_addr = 4'(r);
            bus.rs2_addr = 4'(16 - r);
            expect_out("rd_after_reset_rs1", SelRs1, 32'h0);
            expect_out("rd_after_reset_rs2", SelRs2, 32'h0);
            step();
        end
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        expect_out("idle_pending", SelPend, 32'h0);
        expect_out("idle_stall", SelStl, 32'h0);
        step();

        // Same-cycle bypass, then the committed value
        wb(4'd3, 1'b0, 16'h0000, 16'hBEEF);
        bus.rs1_addr = 4'd3;
        expect_out("bypass_r3", SelRs1, 32'hBEEF);
        step();
        bus.wb_valid            = 1'b0;
        bus.wb_addr             = 'x;
        bus.calc_data_in        = 'x;
        bus.data_from_memory_in = 'x;
        bus.wb_mem_to_reg       = 'x;
        bus.rs2_addr            = 4'd4;
        expect_out("commit_r3", SelRs1, 32'hBEEF);
        expect_out("x_wb_idle_rs2", SelRs2, 32'h0);
        expect_out("x_wb_idle_pending", SelPend, 32'h0);
        step();
        idle_bus();

        // RAW hazard on r5
        issue(4'd5, 1'b1, 4'd0, 4'd0);
        expect_out("issue_r5_stall", SelStl, 32'h0);
        step();
        issue(4'd6, 1'b1, 4'd0, 4'd5);
        expect_out("raw_r5_stall", SelStl, 32'h1);
        expect_out("raw_r5_pending", SelPend, 32'h0020);
        step();
        expect_out("stalled_no_change", SelPend, 32'h0020);
        step();
        wb(4'd5, 1'b1, 16'h1234, 16'h0000);
        expect_out("wb_r5_unstall", SelStl, 32'h0);
        expect_out("wb_r5_bypass", SelRs2, 32'h1234);
        step();
        bus.wb_valid = 1'b0;
        bus.issue_valid = 1'b0;
        expect_out("r6_set_r5_clr", SelPend, 32'h0040);
        expect_out("commit_r5", SelRs2, 32'h1234);
        step();

        // WAW hazard on r6; a non-writing issue ignores its rd
        issue(4'd6, 1'b1, 4'd0, 4'd0);
        expect_out("waw_r6_stall", SelStl, 32'h1);
        step();
        bus.issue_writes = 1'b0;
        expect_out("nowrite_r6_stall", SelStl, 32'h0);
        step();

        // Set wins over clear on r7
        issue(4'd7, 1'b1, 4'd0, 4'd0);
        step();
        bus.issue_valid = 1'b0;
        expect_out("pending_r6_r7", SelPend, 32'h00C0);
        step();
        wb(4'd7, 1'b0, 16'h0000, 16'h7777);
        issue(4'd7, 1'b1, 4'd0, 4'd0);
        expect_out("r7_clr_set_stall", SelStl, 32'h0);
        step();
        bus.wb_valid    = 1'b0;
        bus.issue_valid = 1'b0;
        expect_out("r7_set_wins", SelPend, 32'h00C0);
        step();
        wb(4'd6, 1'b0, 16'h0000, 16'h0606);
        bus.rs1_addr = 4'd7;
        bus.rs2_addr = 4'd6;
        expect_out("commit_r7", SelRs1, 32'h7777);
        expect_out("bypass_r6", SelRs2, 32'h0606);
        step();
        idle_bus();
        expect_out("r6_cleared", SelPend, 32'h0080);
        step();

        // Register 0 is hardwired
        wb(4'd0, 1'b0, 16'h0000, 16'hFFFF);
        issue(4'd0, 1'b1, 4'd0, 4'd0);
        expect_out("r0_bypass_zero", SelRs1, 32'h0);
        expect_out("r0_stall", SelStl, 32'h0);
        step();
        idle_bus();
        expect_out("r0_pending", SelPend, 32'h0080);
        expect_out("r0_read_zero", SelRs1, 32'h0);
        step();

        // Asynchronous reset between edges
        issue(4'd2, 1'b1, 4'd0, 4'd0);
        step();
        issue(4'd9, 1'b1, 4'd0, 4'd0);
        step();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 4'd3;
        expect_out("pending_r2_r7_r9", SelPend, 32'h0284);
        expect_out("pre_reset_r3", SelRs1, 32'hBEEF);
        step();
        #2;
        reset = 1'b1;
        issue(4'd9, 1'b1, 4'd3, 4'd5);
        expect_out("async_rst_pending", SelPend, 32'h0);
        expect_out("async_rst_r3", SelRs1, 32'h0);
        expect_out("async_rst_r5", SelRs2, 32'h0);
        expect_out("async_rst_stall", SelStl, 32'h0);
        step();
        reset = 1'b0;
        idle_bus();
        bus.rs1_addr = 4'd7;
        expect_out("post_rst_r7", SelRs1, 32'h0);
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
